// File: rtl/whack_round_scheduler.sv
// Whack-a-mole round controller: picks a non-repeating target box from the LFSR
// mapper, waits for a hit or timeout, scores each round and sequences a game.
module whack_round_scheduler #(
  parameter int unsigned PRESENT_CYCLES = 25_000_000,
  parameter int unsigned GAP_CYCLES     = 12_500_000,
  parameter int unsigned NUM_ROUNDS     = 16,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned CNT_W          = 8,
  localparam int unsigned RND_W         = $clog2(NUM_ROUNDS + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset_signal,
  input  logic             start,
  input  logic [2:0]       lfsr_box,
  input  logic             hit_valid,
  input  logic [2:0]       hit_box,
  output logic [2:0]       target_box,
  output logic             target_valid,
  output logic             result_valid,
  output logic             result_hit,
  output logic [CNT_W-1:0] score,
  output logic [CNT_W-1:0] misses,
  output logic [CNT_W-1:0] wrong_hits,
  output logic [RND_W-1:0] round_count,
  output logic             busy,
  output logic             game_over
);

  localparam int unsigned TMR_MAX = (PRESENT_CYCLES > GAP_CYCLES) ? PRESENT_CYCLES : GAP_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned RET_W   = $clog2(MAX_RETRY + 2);
  localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PRESENT_LOAD = TMR_W'(PRESENT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_PICK, S_PRESENT, S_RESULT, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RET_W-1:0]   retry_q, retry_d;
  logic [2:0]         last_box_q, last_box_d;
  logic [2:0]         target_box_q, target_box_d;
  logic               target_valid_q, target_valid_d;
  logic               result_valid_q, result_valid_d;
  logic               result_hit_q, result_hit_d;
  logic [CNT_W-1:0]   score_q, score_d;
  logic [CNT_W-1:0]   misses_q, misses_d;
  logic [CNT_W-1:0]   wrong_q, wrong_d;
  logic [RND_W-1:0]   round_q, round_d;
  logic               busy_q, busy_d;
  logic               game_over_q, game_over_d;

  logic               sample_ok;
  logic [2:0]         forced_box;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // A sample is usable only if it is a real box and differs from the previous target.
  assign sample_ok  = (lfsr_box >= 3'd1) && (lfsr_box <= 3'd4) && (lfsr_box != last_box_q);
  assign forced_box = ((last_box_q == 3'd4) || (last_box_q == 3'd0)) ? 3'd1 : last_box_q + 3'd1;

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    retry_d        = retry_q;
    last_box_d     = last_box_q;
    target_box_d   = target_box_q;
    result_hit_d   = result_hit_q;
    score_d        = score_q;
    misses_d       = misses_q;
    wrong_d        = wrong_q;
    round_d        = round_q;
    target_valid_d = 1'b0;
    result_valid_d = 1'b0;
    busy_d         = 1'b0;
    game_over_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          score_d    = '0;
          misses_d   = '0;
          wrong_d    = '0;
          round_d    = '0;
          last_box_d = 3'd0;
          timer_d    = GAP_LOAD;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          retry_d = '0;
          state_d = S_PICK;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_PICK: begin
        if (sample_ok || (retry_q == RET_W'(MAX_RETRY))) begin
          target_box_d = sample_ok ? lfsr_box : forced_box;
          last_box_d   = sample_ok ? lfsr_box : forced_box;
          timer_d      = PRESENT_LOAD;
          state_d      = S_PRESENT;
        end else begin
          retry_d = retry_q + RET_W'(1);
        end
      end
      S_PRESENT: begin
        // A correct hit wins over a timeout landing in the same cycle.
        if (hit_valid && (hit_box == target_box_q)) begin
          score_d      = sat_inc(score_q);
          result_hit_d = 1'b1;
          target_box_d = 3'd0;
          round_d      = round_q + RND_W'(1);
          state_d      = S_RESULT;
        end else begin
          if (hit_valid) begin
            wrong_d = sat_inc(wrong_q);
          end
          if (timer_q == '0) begin
            misses_d     = sat_inc(misses_q);
            result_hit_d = 1'b0;
            target_box_d = 3'd0;
            round_d      = round_q + RND_W'(1);
            state_d      = S_RESULT;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      S_RESULT: begin
        if (round_q == RND_W'(NUM_ROUNDS)) begin
          state_d = S_DONE;
        end else begin
          timer_d = GAP_LOAD;
          state_d = S_GAP;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status flags are registered copies of the state being entered.
    target_valid_d = (state_d == S_PRESENT);
    result_valid_d = (state_d == S_RESULT);
    busy_d         = (state_d == S_GAP) || (state_d == S_PICK) ||
                     (state_d == S_PRESENT) || (state_d == S_RESULT);
    game_over_d    = (state_d == S_DONE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset_signal) begin
    if (reset_signal) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      retry_q        <= '0;
      last_box_q     <= 3'd0;
      target_box_q   <= 3'd0;
      target_valid_q <= 1'b0;
      result_valid_q <= 1'b0;
      result_hit_q   <= 1'b0;
      score_q        <= '0;
      misses_q       <= '0;
      wrong_q        <= '0;
      round_q        <= '0;
      busy_q         <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      last_box_q     <= last_box_d;
      target_box_q   <= target_box_d;
      target_valid_q <= target_valid_d;
      result_valid_q <= result_valid_d;
      result_hit_q   <= result_hit_d;
      score_q        <= score_d;
      misses_q       <= misses_d;
      wrong_q        <= wrong_d;
      round_q        <= round_d;
      busy_q         <= busy_d;
      game_over_q    <= game_over_d;
    end
  end

  assign target_box   = target_box_q;
  assign target_valid = target_valid_q;
  assign result_valid = result_valid_q;
  assign result_hit   = result_hit_q;
  assign score        = score_q;
  assign misses       = misses_q;
  assign wrong_hits   = wrong_q;
  assign round_count  = round_q;
  assign busy         = busy_q;
  assign game_over    = game_over_q;

endmodule

// File: tb/tb_whack_round_scheduler.sv
// Directed bench for whack_round_scheduler with small timing parameters.
module tb_whack_round_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] lfsr_box;
  logic       hit_valid;
  logic [2:0] hit_box;
  logic [2:0] target_box;
  logic       target_valid;
  logic       result_valid;
  logic       result_hit;
  logic [7:0] score;
  logic [7:0] misses;
  logic [7:0] wrong_hits;
  logic [1:0] round_count;
  logic       busy;
  logic       game_over;

  whack_round_scheduler #(
    .PRESENT_CYCLES(8),
    .GAP_CYCLES    (4),
    .NUM_ROUNDS    (3),
    .MAX_RETRY     (3),
    .CNT_W         (8)
  ) dut (
    .CLOCK_50    (clk),
    .reset_signal(rst),
    .start       (start),
    .lfsr_box    (lfsr_box),
    .hit_valid   (hit_valid),
    .hit_box     (hit_box),
    .target_box  (target_box),
    .target_valid(target_valid),
    .result_valid(result_valid),
    .result_hit  (result_hit),
    .score       (score),
    .misses      (misses),
    .wrong_hits  (wrong_hits),
    .round_count (round_count),
    .busy        (busy),
    .game_over   (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] tbox;
    logic       tv;
    logic       rv;
    logic       rh;
    logic [7:0] sc;
    logic [7:0] mi;
    logic [7:0] wr;
    logic [1:0] rc;
    logic       bz;
    logic       go;
  } outs_t;

  typedef struct {
    string      tag;
    int         n;
    logic       st;
    logic [2:0] lf;
    logic       hv;
    logic [2:0] hb;
    outs_t      e;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic void add(string tag, int n, logic st, logic [2:0] lf, logic hv,
                              logic [2:0] hb, logic [2:0] tb, logic tv, logic rv, logic rh,
                              int sc, int mi, int wr, int rc, logic bz, logic go);
    vec_t v;
    v.tag    = tag;
    v.n      = n;
    v.st     = st;
    v.lf     = lf;
    v.hv     = hv;
    v.hb     = hb;
    v.e.tbox = tb;
    v.e.tv   = tv;
    v.e.rv   = rv;
    v.e.rh   = rh;
    v.e.sc   = 8'(sc);
    v.e.mi   = 8'(mi);
    v.e.wr   = 8'(wr);
    v.e.rc   = 2'(rc);
    v.e.bz   = bz;
    v.e.go   = go;
    vq.push_back(v);
  endfunction

  function automatic string fmt(outs_t o);
    return $sformatf("tb=%0d tv=%0b rv=%0b rh=%0b sc=%0d mi=%0d wr=%0d rc=%0d busy=%0b go=%0b",
                     o.tbox, o.tv, o.rv, o.rh, o.sc, o.mi, o.wr, o.rc, o.bz, o.go);
  endfunction

  // result_hit is only meaningful alongside result_valid.
  task automatic check(string tag, outs_t e);
    outs_t g;
    g.tbox = target_box;
    g.tv   = target_valid;
    g.rv   = result_valid;
    g.rh   = result_hit;
    g.sc   = score;
    g.mi   = misses;
    g.wr   = wrong_hits;
    g.rc   = round_count;
    g.bz   = busy;
    g.go   = game_over;
    if (!e.rv) g.rh = e.rh;
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got {%s} want {%s}", tag, fmt(g), fmt(e));
    end
  endtask

  outs_t zero_o;

  initial begin
    zero_o    = '0;
    rst       = 1'b1;
    start     = 1'b0;
    lfsr_box  = 3'd0;
    hit_valid = 1'b0;
    hit_box   = 3'd0;
    #3;
    check("reset asserted", zero_o);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle no start", zero_o);

    // tag, n, st, lf, hv, hb | tb, tv, rv, rh, sc, mi, wr, rc, busy, go
    add("g1 start",       1, 1, 2, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0);
    add("g1 start ign",   4, 1, 2, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0);
    add("g1r1 lit",       1, 0, 2, 0, 0,  2, 1, 0, 0,  0, 0, 0, 0,  1, 0);
    add("g1r1 held",      7, 0, 2, 0, 0,  2, 1, 0, 0,  0, 0, 0, 0,  1, 0);
    add("g1r1 timeout",   1, 0, 2, 0, 0,  0, 0, 1, 0,  0, 1, 0, 1,  1, 0);
    add("g1r2 gap",       1, 0, 2, 0, 0,  0, 0, 0, 0,  0, 1, 0, 1,  1, 0);
    add("g1r2 pick",      4, 0, 2, 0, 0,  0, 0, 0, 0,  0, 1, 0, 1,  1, 0);
    add("g1r2 rejects",   3, 0, 2, 0, 0,  0, 0, 0, 0,  0, 1, 0, 1,  1, 0);
    add("g1r2 forced",    1, 0, 2, 0, 0,  3, 1, 0, 0,  0, 1, 0, 1,  1, 0);
    add("g1r2 lit",       2, 0, 2, 0, 0,  3, 1, 0, 0,  0, 1, 0, 1,  1, 0);
    add("g1r2 hit",       1, 0, 2, 1, 3,  0, 0, 1, 1,  1, 1, 0, 2,  1, 0);
    add("g1r3 gap",       1, 0, 4, 0, 0,  0, 0, 0, 0,  1, 1, 0, 2,  1, 0);
    add("g1r3 pick",      4, 0, 4, 0, 0,  0, 0, 0, 0,  1, 1, 0, 2,  1, 0);
    add("g1r3 lit",       1, 0, 4, 0, 0,  4, 1, 0, 0,  1, 1, 0, 2,  1, 0);
    add("g1r3 wrong1",    1, 0, 4, 1, 1,  4, 1, 0, 0,  1, 1, 1, 2,  1, 0);
    add("g1r3 quiet",     1, 0, 4, 0, 0,  4, 1, 0, 0,  1, 1, 1, 2,  1, 0);
    add("g1r3 wrong2",    1, 0, 4, 1, 2,  4, 1, 0, 0,  1, 1, 2, 2,  1, 0);
    add("g1r3 held",      4, 0, 4, 0, 0,  4, 1, 0, 0,  1, 1, 2, 2,  1, 0);
    add("g1r3 timeout",   1, 0, 4, 0, 0,  0, 0, 1, 0,  1, 2, 2, 3,  1, 0);
    add("g1 done",        1, 0, 4, 0, 0,  0, 0, 0, 0,  1, 2, 2, 3,  0, 1);
    add("done hit ign",   1, 0, 4, 1, 4,  0, 0, 0, 0,  1, 2, 2, 3,  0, 1);
    add("done hold",      3, 0, 4, 0, 0,  0, 0, 0, 0,  1, 2, 2, 3,  0, 1);
    add("g2 restart",     1, 1, 4, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0);
    add("g2r1 pick",      4, 0, 4, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,  1, 0);
    add("g2r1 lit",       1, 0, 4, 0, 0,  4, 1, 0, 0,  0, 0, 0, 0,  1, 0);
    add("g2r1 held",      7, 0, 4, 0, 0,  4, 1, 0, 0,  0, 0, 0, 0,  1, 0);
    add("g2r1 last hit",  1, 0, 4, 1, 4,  0, 0, 1, 1,  1, 0, 0, 1,  1, 0);
    add("g2r2 gap ign",   1, 0, 4, 1, 4,  0, 0, 0, 0,  1, 0, 0, 1,  1, 0);
    add("g2r2 pick",      4, 0, 4, 0, 0,  0, 0, 0, 0,  1, 0, 0, 1,  1, 0);
    add("g2r2 rejects",   3, 0, 4, 0, 0,  0, 0, 0, 0,  1, 0, 0, 1,  1, 0);
    add("g2r2 forced 1",  1, 0, 4, 0, 0,  1, 1, 0, 0,  1, 0, 0, 1,  1, 0);
    add("g2r2 held",      7, 0, 4, 0, 0,  1, 1, 0, 0,  1, 0, 0, 1,  1, 0);
    add("g2r2 timeout",   1, 0, 4, 0, 0,  0, 0, 1, 0,  1, 1, 0, 2,  1, 0);
    add("g2r3 gap",       1, 0, 4, 0, 0,  0, 0, 0, 0,  1, 1, 0, 2,  1, 0);
    add("g2r3 pick",      4, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0, 2,  1, 0);
    add("g2r3 rej 0",     1, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0, 2,  1, 0);
    add("g2r3 rej 7",     1, 0, 7, 0, 0,  0, 0, 0, 0,  1, 1, 0, 2,  1, 0);
    add("g2r3 accept 3",  1, 0, 3, 0, 0,  3, 1, 0, 0,  1, 1, 0, 2,  1, 0);
    add("g2r3 lit",       2, 0, 3, 0, 0,  3, 1, 0, 0,  1, 1, 0, 2,  1, 0);

    foreach (vq[i]) begin
      start     = vq[i].st;
      lfsr_box  = vq[i].lf;
      hit_valid = vq[i].hv;
      hit_box   = vq[i].hb;
      repeat (vq[i].n) @(posedge clk);
      #1;
      check(vq[i].tag, vq[i].e);
    end

    // Asynchronous reset in the middle of a PRESENT cycle.
    start     = 1'b0;
    hit_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async reset", zero_o);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post reset idle", zero_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/whack_round_scheduler.md
Name: whack_round_scheduler

Overview:
- Game-round controller for the whack-a-mole datapath. It samples the mapped random box number (1..4) from the LFSR mapper and presents one target box per round.
- Each round it waits for a matching hit or a timeout, then scores the round and sequences a fixed number of rounds per game.
- Sits between the LFSR/box mapper and the hit detection, LED and HEX display logic.

Parameters:
- PRESENT_CYCLES, 25_000_000, clock cycles the target stays lit per round (0.5 s at 50 MHz); must be >= 1.
- GAP_CYCLES, 12_500_000, idle clock cycles between rounds; must be >= 1.
- NUM_ROUNDS, 16, rounds per game; must be >= 1.
- MAX_RETRY, 3, rejected samples allowed before a forced pick.
- CNT_W, 8, width of the score, miss and wrong-hit counters.

Ports:
- CLOCK_50, in, 1, system clock, 50 MHz.
- reset_signal, in, 1, asynchronous, active-high reset.
- start, in, 1, level; sampled only in IDLE or DONE.
- lfsr_box, in, 3, mapped box from the LFSR; valid values are 1..4. Changes every clock.
- hit_valid, in, 1, single-cycle pulse: a box was struck.
- hit_box, in, 3, box struck (1..4); qualified by hit_valid.
- target_box, out, 3, current lit box 1..4; 0 when no target is lit.
- target_valid, out, 1, high while in PRESENT.
- result_valid, out, 1, one-cycle pulse at the end of each round.
- result_hit, out, 1, qualified by result_valid: 1 = hit, 0 = timeout.
- score, out, CNT_W, correct hits this game; saturates at all-ones.
- misses, out, CNT_W, timed-out rounds; saturates.
- wrong_hits, out, CNT_W, hits on a non-target box during PRESENT; saturates.
- round_count, out, clog2(NUM_ROUNDS+1), completed rounds.
- busy, out, 1, high in GAP, PICK, PRESENT and RESULT.
- game_over, out, 1, high in DONE.

Behaviour:
- Reset (async, any state): state=IDLE. All outputs and counters are 0, last_box=0, timers=0.
- States: IDLE, GAP, PICK, PRESENT, RESULT, DONE.
- IDLE: when start=1, clear score, misses, wrong_hits, round_count and last_box; load gap timer with GAP_CYCLES-1; go to GAP.
- GAP: decrement the timer each cycle. At 0, go to PICK with retry_cnt=0. GAP lasts exactly GAP_CYCLES cycles.
- PICK: samples lfsr_box each cycle in this state.
  - Reject the sample if lfsr_box is not in 1..4 or equals last_box; on reject increment retry_cnt and stay in PICK.
  - If retry_cnt==MAX_RETRY, force the pick: (last_box==4 or last_box==0) ? 1 : last_box+1.
  - On accept or force: target_box and last_box <= pick; load present timer with PRESENT_CYCLES-1; go to PRESENT.
  - PICK lasts 1..MAX_RETRY+1 cycles.
- PRESENT: target_valid=1 and target_box held.
  - hit_valid with hit_box==target_box: score++, result_hit<=1, go to RESULT.
  - hit_valid with a non-matching hit_box: wrong_hits++, stay in PRESENT, timer keeps running.
  - Timer reaches 0 with no correct hit: misses++, result_hit<=0, go to RESULT.
  - A correct hit in the same cycle the timer expires counts as a hit; misses is not incremented.
- hit_valid outside PRESENT is ignored; no counter changes.
- RESULT (exactly 1 cycle): result_valid=1, target_box=0, target_valid=0, round_count++.
  - If the new round_count==NUM_ROUNDS, go to DONE.
  - Otherwise load the gap timer and go to GAP.
- DONE: game_over=1; counters hold for display. start=1 performs the same clear as IDLE and goes to GAP.
- start is ignored while busy.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Round latency from the end of the previous round: GAP_CYCLES + PICK cycles, then up to PRESENT_CYCLES.
- All outputs are registered; no combinational path from any input to any output.

Test Plan (PRESENT_CYCLES=8, GAP_CYCLES=4, NUM_ROUNDS=3, MAX_RETRY=3):
- Start and timing: reset, pulse start with lfsr_box=2 → busy rises. target_valid=1 with target_box=2 exactly 5 cycles after the start edge and held for 8 cycles. result_valid pulse with result_hit=0; misses=1.
- Correct hit: lfsr_box=3 picked, hit_valid with hit_box=3 on the 3rd PRESENT cycle → next cycle result_valid=1, result_hit=1, score=1. target_box=0 in RESULT.
- Wrong hit then timeout: target 4, hit_box=1 then hit_box=2 during PRESENT → wrong_hits=2, PRESENT still lasts a full 8 cycles, misses=1. A correct hit in the last PRESENT cycle instead gives score=1, misses=0.
- Repeat rejection: last_box=2, lfsr_box held at 2 → PICK lasts 4 cycles, target_box=3. With last_box=4 held → target_box=1. lfsr_box=0 or 7 is rejected.
- Game end and restart: complete 3 rounds → game_over=1, busy=0, round_count=3, counters held. hit_valid in DONE changes nothing. start → all counters 0, GAP entered.
- Async reset: assert reset_signal mid-PRESENT between clock edges → all outputs 0 immediately, state IDLE. Deasserting it without start leaves the block idle.
